// File: rtl/maj_eval_pkg.sv
// Shared types, sizes and operand decode for the programmable MAJ-3 chain evaluator.
package maj_eval_pkg;

  localparam int NUM_IN    = 7;
  localparam int MAX_NODES = 8;
  localparam int SEL_W     = $clog2(1 + NUM_IN + MAX_NODES);
  localparam int NODE_W    = 3 * (SEL_W + 1);
  localparam int ADDR_W    = $clog2(MAX_NODES);
  localparam int NUM_W     = $clog2(MAX_NODES + 1);
  localparam int SRC_W     = 1 << SEL_W;

  localparam logic [SEL_W-1:0] SEL_ZERO = '0;

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  typedef struct packed {
    logic             inv_c;
    logic [SEL_W-1:0] sel_c;
    logic             inv_b;
    logic [SEL_W-1:0] sel_b;
    logic             inv_a;
    logic [SEL_W-1:0] sel_a;
  } node_t;

  // Operand space is {nodes, x, const0}, zero-padded so unused codes read 0.
  function automatic logic pick_operand(input logic [SEL_W-1:0]     sel,
                                        input logic [NUM_IN-1:0]    x,
                                        input logic [MAX_NODES-1:0] nodes);
    logic [SRC_W-1:0] src;
    src = SRC_W'({nodes, x, 1'b0});
    return src[sel];
  endfunction

endpackage

// File: rtl/maj_chain_eval_if.sv
// Config, input and result handshake bundle for maj_chain_eval.
// MAJ_EVAL_TRACE_EN adds the out_nodes trace bus.
interface maj_chain_eval_if;
  import maj_eval_pkg::*;

  logic                 cfg_we;
  logic [ADDR_W-1:0]    cfg_addr;
  node_t                cfg_data;
  logic [NUM_W-1:0]     cfg_num_nodes;
  logic                 cfg_err;
  logic                 in_valid;
  logic                 in_ready;
  logic [NUM_IN-1:0]    in_x;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_y;
`ifdef MAJ_EVAL_TRACE_EN
  logic [MAX_NODES-1:0] out_nodes;

  modport master (output cfg_we, cfg_addr, cfg_data, cfg_num_nodes, in_valid, in_x, out_ready,
                  input  cfg_err, in_ready, out_valid, out_y, out_nodes);
  modport slave  (input  cfg_we, cfg_addr, cfg_data, cfg_num_nodes, in_valid, in_x, out_ready,
                  output cfg_err, in_ready, out_valid, out_y, out_nodes);
`else
  modport master (output cfg_we, cfg_addr, cfg_data, cfg_num_nodes, in_valid, in_x, out_ready,
                  input  cfg_err, in_ready, out_valid, out_y);
  modport slave  (input  cfg_we, cfg_addr, cfg_data, cfg_num_nodes, in_valid, in_x, out_ready,
                  output cfg_err, in_ready, out_valid, out_y);
`endif

endinterface

// File: rtl/maj_chain_eval_maj3_inv.sv
// Combinational three-input majority gate with a complement control per operand.
module maj3_inv (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic inv_a,
  input  logic inv_b,
  input  logic inv_c,
  output logic y
);

  logic ea, eb, ec;

  assign ea = a ^ inv_a;
  assign eb = b ^ inv_b;
  assign ec = c ^ inv_c;
  assign y  = (ea & eb) | (ea & ec) | (eb & ec);

endmodule

// File: rtl/maj_chain_eval.sv
// Sequential MAJ-3 network evaluator: one table node per cycle, result via valid/ready.
// MAJ_EVAL_TRACE_EN exposes all node registers on out_nodes.
module maj_chain_eval
  import maj_eval_pkg::*;
(
  input logic            clk,
  input logic            rst_n,
  maj_chain_eval_if.slave bus
);

  state_t               state, state_next;
  node_t                tbl [MAX_NODES];
  node_t                cur;
  node_t                pend_data;
  logic [ADDR_W-1:0]    pend_addr;
  logic                 pend_valid;
  logic [ADDR_W-1:0]    idx;
  logic [NUM_W-1:0]     num, n_sat;
  logic [NUM_IN-1:0]    x_q;
  logic [MAX_NODES-1:0] nodes;
  logic                 out_y_q, cfg_err_q;
  logic                 ready, valid, accept, last;
  logic                 addr_ok, wr_ok;
  logic                 op_a, op_b, op_c, node_val;

  // Every encodable address is in range when MAX_NODES is a power of two.
  if ((1 << ADDR_W) == MAX_NODES) begin : g_addr_full
    assign addr_ok = 1'b1;
  end else begin : g_addr_part
    assign addr_ok = bus.cfg_addr < ADDR_W'(MAX_NODES);
  end

  assign n_sat  = (bus.cfg_num_nodes > NUM_W'(MAX_NODES)) ? NUM_W'(MAX_NODES) : bus.cfg_num_nodes;
  assign last   = (NUM_W'(idx) == num - NUM_W'(1));
  assign accept = bus.in_valid && ready;
  assign wr_ok  = rst_n && bus.cfg_we && (state == IDLE) && addr_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    valid      = 1'b0;
    unique case (state)
      IDLE: begin
        ready = rst_n;
        if (accept) state_next = (n_sat != '0) ? EVAL : DONE;
      end
      EVAL: if (last) state_next = DONE;
      DONE: begin
        valid = rst_n;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A write that coincides with an accept is parked so the accepted vector sees the old table.
  always_ff @(posedge clk) begin
    if (!rst_n)                 pend_valid <= 1'b0;
    else if (wr_ok && accept)   pend_valid <= 1'b1;
    else if (state == DONE)     pend_valid <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_ok && accept) begin
      pend_addr <= bus.cfg_addr;
      pend_data <= bus.cfg_data;
    end
    if (pend_valid && (state == DONE || !rst_n))
      tbl[pend_addr] <= pend_data;
    else if (wr_ok && !accept)
      tbl[bus.cfg_addr] <= bus.cfg_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cfg_err_q <= 1'b0;
    else        cfg_err_q <= bus.cfg_we && !((state == IDLE) && addr_ok);
  end

  assign cur  = tbl[idx];
  assign op_a = pick_operand(cur.sel_a, x_q, nodes);
  assign op_b = pick_operand(cur.sel_b, x_q, nodes);
  assign op_c = pick_operand(cur.sel_c, x_q, nodes);

  maj3_inv u_maj (
    .a     (op_a),
    .b     (op_b),
    .c     (op_c),
    .inv_a (cur.inv_a),
    .inv_b (cur.inv_b),
    .inv_c (cur.inv_c),
    .y     (node_val)
  );

  // Clearing nodes on accept makes forward and self references read 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx     <= '0;
      num     <= '0;
      x_q     <= '0;
      nodes   <= '0;
      out_y_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          idx     <= '0;
          num     <= n_sat;
          x_q     <= bus.in_x;
          nodes   <= '0;
          out_y_q <= 1'b0;
        end
        EVAL: begin
          nodes[idx] <= node_val;
          idx        <= idx + 1'b1;
          if (last) out_y_q <= node_val;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid;
  assign bus.out_y     = out_y_q;
  assign bus.cfg_err   = cfg_err_q;
`ifdef MAJ_EVAL_TRACE_EN
  assign bus.out_nodes = nodes;
`endif

endmodule
